// File: rtl/fifo_pkg.sv
// Constants shared by the synchronous and asynchronous FIFOs.
// Selects between standard registered read and first-word fall-through.
package fifo_pkg;

  localparam int MODE_STD  = 0;
  localparam int MODE_FWFT = 1;

endpackage : fifo_pkg

// File: rtl/fifo_mem.sv
// FIFO storage: one registered write port and an asynchronous read port.
// Stored words are not reset; the FIFO pointers decide what is valid.
module fifo_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule : fifo_mem

// File: rtl/sync_fifo_fwft.sv
// Single-clock FIFO with count, registered status flags, error pulses and
// either a registered read port or a first-word fall-through read port.
module sync_fifo_fwft
  import fifo_pkg::*;
#(
  parameter int  DATA_WIDTH  = 8,
  parameter int  FIFO_DEPTH  = 16,
  parameter int  FIFO_AFULL  = FIFO_DEPTH - 1,
  parameter int  FIFO_AEMPTY = 1,
  parameter int  FWFT        = 0,
  localparam int ADDR_WIDTH  = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty,
  output logic                  afull,
  output logic                  aempty,
  output logic [ADDR_WIDTH:0]   fifo_cnt,
  output logic                  wr_err,
  output logic                  rd_err
);

  localparam logic [ADDR_WIDTH:0] DEPTH_CNT  = (ADDR_WIDTH + 1)'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH:0] AFULL_CNT  = (ADDR_WIDTH + 1)'(FIFO_AFULL);
  localparam logic [ADDR_WIDTH:0] AEMPTY_CNT = (ADDR_WIDTH + 1)'(FIFO_AEMPTY);
  localparam logic                AFULL_RST  = (AFULL_CNT == '0);
  localparam logic                IS_FWFT    = (FWFT == MODE_FWFT);

  logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  afull_q, afull_d;
  logic                  aempty_q, aempty_d;
  logic                  wr_err_q, wr_err_d;
  logic                  rd_err_q, rd_err_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  wr_vld;
  logic                  rd_vld;

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_vld),
    .wr_addr (wr_ptr_q[ADDR_WIDTH-1:0]),
    .wr_data (wr_data),
    .rd_addr (rd_ptr_q[ADDR_WIDTH-1:0]),
    .rd_data (head_data)
  );

  assign wr_vld = wr_en && !full_q;
  assign rd_vld = rd_en && !empty_q;

  // Flags are derived from the next count so they line up with fifo_cnt.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    rd_data_d = rd_data_q;

    if (wr_vld) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (rd_vld) begin
      rd_ptr_d  = rd_ptr_q + 1'b1;
      rd_data_d = head_data;
    end

    case ({wr_vld, rd_vld})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    full_d   = (cnt_d == DEPTH_CNT);
    empty_d  = (cnt_d == '0);
    afull_d  = (cnt_d >= AFULL_CNT);
    aempty_d = (cnt_d <= AEMPTY_CNT);
    wr_err_d = wr_en && full_q;
    rd_err_d = rd_en && empty_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      afull_q   <= AFULL_RST;
      aempty_q  <= 1'b1;
      wr_err_q  <= 1'b0;
      rd_err_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      afull_q   <= afull_d;
      aempty_q  <= aempty_d;
      wr_err_q  <= wr_err_d;
      rd_err_q  <= rd_err_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Fall-through mode exposes the head word directly while data is present.
  assign rd_data  = (IS_FWFT && !empty_q) ? head_data : rd_data_q;
  assign full     = full_q;
  assign empty    = empty_q;
  assign afull    = afull_q;
  assign aempty   = aempty_q;
  assign fifo_cnt = cnt_q;
  assign wr_err   = wr_err_q;
  assign rd_err   = rd_err_q;

endmodule : sync_fifo_fwft
